sysbus_arbiter: RTL

Two-requester arbiter that shares the single Sysbus between the core's instruction-fetch port (port 0) and data-memory port (port 1). It sits between the Core front-end/memory stage and the top-level Sysbus. It allows exactly one transaction on the bus at a time: it registers the winning request, drives write-data beats, and steers the 8-beat line response back to the owning requester.

---
 rtl/sysbus_arb_pkg.sv | 24 ++
 rtl/sysbus_arb_pick.sv | 30 +++
 rtl/sysbus_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sysbus_arb_pkg.sv
//==============================================================================
// Module : sysbus_arb_pkg
// Desc   : Shared types and constants for the two-port Sysbus arbiter.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package sysbus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam int   TAG_RW_BIT = 12;
    localparam logic TAG_READ   = 1'b1;
    localparam logic TAG_WRITE  = 1'b0;
    localparam int   BEATS_LOG2 = 3;

endpackage

`default_nettype wire

// File: rtl/sysbus_arb_pick.sv
//==============================================================================
// Module : sysbus_arb_pick
// Desc   : Combinational 2-way winner select. Round-robin when SYSBUS_ARB_RR_EN
//          is defined, otherwise fixed priority with port 1 winning ties.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sysbus_arb_pick (
    input  logic [1:0] req,
`ifdef SYSBUS_ARB_RR_EN
    input  logic       ptr,
`endif
    output logic       grant_valid,
    output logic       grant
);

    always_comb begin
        grant_valid = |req;
`ifdef SYSBUS_ARB_RR_EN
        // On a tie the pointer names the preferred port
        grant = (req == 2'b11) ? ptr : req[1];
`else
        grant = req[1];
`endif
    end

endmodule

`default_nettype wire

// File: rtl/sysbus_arbiter.sv
//==============================================================================
// Module : sysbus_arbiter
// Desc   : Shares the Sysbus between instruction-fetch (port 0) and data (port 1)
//          requesters, one transaction at a time. SYSBUS_ARB_RR_EN selects
//          round-robin arbitration; default build is fixed priority.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sysbus_arbiter
    import sysbus_arb_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int TAG_W  = 13,
    parameter int BEATS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_reqcyc,
    input  logic [ADDR_W-1:0] m0_req,
    input  logic [TAG_W-1:0]  m0_reqtag,
    output logic              m0_reqack,
    output logic [63:0]       m0_resp,
    output logic              m0_respcyc,
    input  logic              m0_respack,
    input  logic              m1_reqcyc,
    input  logic [ADDR_W-1:0] m1_req,
    input  logic [TAG_W-1:0]  m1_reqtag,
    output logic              m1_reqack,
    output logic [63:0]       m1_resp,
    output logic              m1_respcyc,
    input  logic              m1_respack,
    output logic              bus_reqcyc,
    output logic [ADDR_W-1:0] bus_req,
    output logic [TAG_W-1:0]  bus_reqtag,
    input  logic              bus_reqack,
    input  logic [63:0]       bus_resp,
    input  logic              bus_respcyc,
    output logic              bus_respack
);

    localparam logic [BEATS_LOG2-1:0] c_last_beat = BEATS_LOG2'(BEATS - 1);

    arb_state_t              r_state;
    arb_state_t              w_next_state;
    logic                    r_owner;
    logic [BEATS_LOG2-1:0]   r_cnt;
    logic [ADDR_W-1:0]       r_req;
    logic [TAG_W-1:0]        r_tag;
    logic                    w_grant_valid;
    logic                    w_grant;
    logic                    w_owner_respack;
    logic                    w_owner_reqcyc;
    logic                    w_beat_acc;
    logic                    w_last;
    logic                    w_done;

    assign w_owner_respack = r_owner ? m1_respack : m0_respack;
    assign w_owner_reqcyc  = r_owner ? m1_reqcyc  : m0_reqcyc;
    assign w_beat_acc      = (r_state == ST_RESP) && bus_respcyc && w_owner_respack;
    assign w_last          = (r_cnt == c_last_beat);
    assign w_done          = ((r_state == ST_WDATA) || w_beat_acc) && w_last;

`ifdef SYSBUS_ARB_RR_EN
    logic r_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else if (w_done) begin
            r_ptr <= ~r_owner;
        end
    end

    sysbus_arb_pick u_pick (
        .req         ({m1_reqcyc, m0_reqcyc}),
        .ptr         (r_ptr),
        .grant_valid (w_grant_valid),
        .grant       (w_grant)
    );
`else
    sysbus_arb_pick u_pick (
        .req         ({m1_reqcyc, m0_reqcyc}),
        .grant_valid (w_grant_valid),
        .grant       (w_grant)
    );
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latched request and beat counter; counter clears as the FSM leaves to IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner <= 1'b0;
            r_req   <= '0;
            r_tag   <= '0;
            r_cnt   <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_grant_valid) begin
                r_owner <= w_grant;
                r_req   <= w_grant ? m1_req    : m0_req;
                r_tag   <= w_grant ? m1_reqtag : m0_reqtag;
            end
            if (w_done) begin
                r_cnt <= '0;
            end else if ((r_state == ST_WDATA) || w_beat_acc) begin
                r_cnt <= r_cnt + BEATS_LOG2'(1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_grant_valid) w_next_state = ST_REQ;
            ST_REQ:   if (bus_reqack) w_next_state = (r_tag[TAG_RW_BIT] == TAG_READ) ? ST_RESP : ST_WDATA;
            ST_WDATA: if (w_last) w_next_state = ST_IDLE;
            ST_RESP:  if (w_beat_acc && w_last) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus_reqcyc  = (r_state == ST_REQ);
        bus_req     = (r_state == ST_WDATA) ? (r_owner ? m1_req : m0_req) : r_req;
        bus_reqtag  = r_tag;
        m0_reqack   = (r_state == ST_REQ) && bus_reqack && !r_owner;
        m1_reqack   = (r_state == ST_REQ) && bus_reqack &&  r_owner;
        m0_resp     = bus_resp;
        m1_resp     = bus_resp;
        m0_respcyc  = (r_state == ST_RESP) && bus_respcyc && !r_owner;
        m1_respcyc  = (r_state == ST_RESP) && bus_respcyc &&  r_owner;
        bus_respack = w_beat_acc;
    end

    a_resp_outside_resp: assert property (@(posedge clk) disable iff (reset)
        bus_respcyc |-> (r_state == ST_RESP));

    a_req_dropped: assert property (@(posedge clk) disable iff (reset)
        (r_state == ST_REQ) |-> w_owner_reqcyc);

endmodule

`default_nettype wire
